// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck execution core: opcode bytes and
// the controller state encoding.
package bf_pkg;

  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_CLOSE = 8'h5D;
  localparam logic [7:0] OP_END   = 8'h00;

  typedef enum logic [3:0] {
    LOAD,
    CAPT,
    FETCH,
    EXEC,
    SKIP_F,
    SKIP_E,
    WAIT_RX,
    WAIT_TX,
    HALT,
    ERR
  } state_t;

endpackage

// File: rtl/bf_loop_stack.sv
// LIFO of loop-start addresses. The top entry is always readable so a
// taken ']' can jump back in a single cycle.
module bf_loop_stack
  import bf_pkg::*;
#(
  parameter int ADDR_CODE   = 9,
  parameter int STACK_DEPTH = 16
) (
  input  logic                 sysClk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [ADDR_CODE-1:0] din,
  output logic [ADDR_CODE-1:0] top,
  output logic                 full,
  output logic                 empty
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int MEM_N = 1 << SP_W;

  logic [SP_W-1:0]      sp_q, sp_d;
  logic [SP_W-1:0]      top_idx;
  logic [ADDR_CODE-1:0] stack_mem [MEM_N];

  assign full    = (sp_q == SP_W'(STACK_DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = sp_q - 1'b1;
  assign top     = stack_mem[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (push && !full) begin
      sp_d = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entries need no reset: only slots below sp are ever read.
  always_ff @(posedge sysClk) begin
    if (push && !full) begin
      stack_mem[sp_q] <= din;
    end
  end

endmodule

// File: rtl/bf_core_stacked.sv
// Brainfuck execution core with a hardware loop stack, depth-counted
// forward skip and ready/valid byte I/O.
module bf_core_stacked
  import bf_pkg::*;
#(
  parameter int ADDR_CODE   = 9,
  parameter int ADDR_ARRAY  = 9,
  parameter int CELL_W      = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic                  sysClk,
  input  logic                  reset,
  output logic [ADDR_CODE-1:0]  code_addr,
  input  logic [7:0]            code_data,
  output logic [ADDR_ARRAY-1:0] arr_addr,
  input  logic [CELL_W-1:0]     arr_rdata,
  output logic [CELL_W-1:0]     arr_wdata,
  output logic                  arr_we,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ack,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_CODE:0] SKIP_ONE = {{ADDR_CODE{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_CODE-1:0]  pc_q, pc_d;
  logic [ADDR_ARRAY-1:0] ptr_q, ptr_d;
  logic [CELL_W-1:0]     cell_q, cell_d;
  logic [ADDR_CODE:0]    skip_q, skip_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  wb_q, wb_d;

  logic                  push, pop, full, empty;
  logic [ADDR_CODE-1:0]  top;
  logic                  adv;
  state_t                adv_to;

  bf_loop_stack #(
    .ADDR_CODE  (ADDR_CODE),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .sysClk(sysClk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_q),
    .top   (top),
    .full  (full),
    .empty (empty)
  );

  assign code_addr = pc_q;
  assign arr_addr  = ptr_q;
  assign done      = (state_q == HALT);
  assign error     = (state_q == ERR);
  assign tx_data   = tx_start ? cell_q[7:0] : tx_data_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ptr_d     = ptr_q;
    cell_d    = cell_q;
    skip_d    = skip_q;
    tx_data_d = tx_data_q;
    wb_d      = 1'b0;
    arr_we    = 1'b0;
    arr_wdata = '0;
    rx_ack    = 1'b0;
    tx_start  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    adv       = 1'b0;
    adv_to    = FETCH;

    unique case (state_q)
      LOAD: state_d = CAPT;

      CAPT: begin
        cell_d  = arr_rdata;
        state_d = FETCH;
      end

      // A received byte is written back here, one cycle after rx_ack,
      // so the two strobes never share a cycle.
      FETCH: begin
        state_d = EXEC;
        if (wb_q) begin
          arr_we    = 1'b1;
          arr_wdata = cell_q;
        end
      end

      EXEC: begin
        case (code_data)
          OP_INC, OP_DEC: begin
            cell_d    = (code_data == OP_DEC) ? cell_q - 1'b1 : cell_q + 1'b1;
            arr_we    = 1'b1;
            arr_wdata = cell_d;
            adv       = 1'b1;
          end
          OP_RIGHT, OP_LEFT: begin
            ptr_d  = (code_data == OP_LEFT) ? ptr_q - 1'b1 : ptr_q + 1'b1;
            adv    = 1'b1;
            adv_to = LOAD;
          end
          OP_OPEN: begin
            if (cell_q == '0) begin
              skip_d = SKIP_ONE;
              adv    = 1'b1;
              adv_to = SKIP_F;
            end else if (full) begin
              state_d = ERR;
            end else begin
              push = 1'b1;
              adv  = 1'b1;
            end
          end
          OP_CLOSE: begin
            if (empty) begin
              state_d = ERR;
            end else if (cell_q != '0) begin
              pc_d    = top + 1'b1;
              state_d = FETCH;
            end else begin
              pop = 1'b1;
              adv = 1'b1;
            end
          end
          OP_OUT:  state_d = WAIT_TX;
          OP_IN:   state_d = WAIT_RX;
          OP_END:  state_d = HALT;
          default: adv = 1'b1;
        endcase
      end

      SKIP_F: state_d = SKIP_E;

      SKIP_E: begin
        case (code_data)
          OP_END: state_d = HALT;
          OP_OPEN: begin
            skip_d = skip_q + 1'b1;
            adv    = 1'b1;
            adv_to = SKIP_F;
          end
          OP_CLOSE: begin
            skip_d = skip_q - 1'b1;
            adv    = 1'b1;
            adv_to = (skip_q == SKIP_ONE) ? FETCH : SKIP_F;
          end
          default: begin
            adv    = 1'b1;
            adv_to = SKIP_F;
          end
        endcase
      end

      WAIT_RX: begin
        if (rx_valid) begin
          cell_d = CELL_W'(rx_data);
          rx_ack = 1'b1;
          wb_d   = 1'b1;
          adv    = 1'b1;
        end
      end

      WAIT_TX: begin
        if (tx_ready) begin
          tx_start  = 1'b1;
          tx_data_d = cell_q[7:0];
          adv       = 1'b1;
        end
      end

      HALT: state_d = HALT;
      ERR:  state_d = ERR;

      default: state_d = ERR;
    endcase

    // Running off the end of code memory halts instead of wrapping.
    if (adv) begin
      if (&pc_q) begin
        state_d = HALT;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = adv_to;
      end
    end

    if (reset) begin
      arr_we   = 1'b0;
      rx_ack   = 1'b0;
      tx_start = 1'b0;
    end
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      state_q   <= LOAD;
      pc_q      <= '0;
      ptr_q     <= '0;
      cell_q    <= '0;
      skip_q    <= '0;
      tx_data_q <= '0;
      wb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ptr_q     <= ptr_d;
      cell_q    <= cell_d;
      skip_q    <= skip_d;
      tx_data_q <= tx_data_d;
      wb_q      <= wb_d;
    end
  end

endmodule
